// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp encodings, phase codes, fault codes and decode classes for the traffic light monitor
package traffic_pkg;

  // Lamp bus encodings (one-hot per lamp)
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Phase codes: {direction[1:0], yellow}
  localparam logic [2:0] PH_N   = 3'd0;
  localparam logic [2:0] PH_N_Y = 3'd1;
  localparam logic [2:0] PH_S   = 3'd2;
  localparam logic [2:0] PH_S_Y = 3'd3;
  localparam logic [2:0] PH_E   = 3'd4;
  localparam logic [2:0] PH_E_Y = 3'd5;
  localparam logic [2:0] PH_W   = 3'd6;
  localparam logic [2:0] PH_W_Y = 3'd7;

  // Fault codes, lower value = higher priority
  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENC      = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_DARK     = 3'd3;
  localparam logic [2:0] FC_SEQ      = 3'd4;
  localparam logic [2:0] FC_EARLY    = 3'd5;
  localparam logic [2:0] FC_LATE     = 3'd6;

  // Per-sample error class produced by the lamp decoder
  typedef enum logic [1:0] {
    DEC_OK       = 2'd0,
    DEC_ENC      = 2'd1,
    DEC_CONFLICT = 2'd2,
    DEC_DARK     = 2'd3
  } dec_err_e;

  // Lock state of the sequence checker
  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  // The only legal successor of a phase is the next code, W_Y wrapping to N
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// rtl/traffic_lamp_decode.sv - combinational decode of four lamp buses into phase, validity and error class
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic [2:0] n_lights_i,
  input  logic [2:0] s_lights_i,
  input  logic [2:0] e_lights_i,
  input  logic [2:0] w_lights_i,
  output logic [2:0] phase_o,
  output logic       phase_valid_o,
  output dec_err_e   err_o
);

  logic [2:0] lamp [4];
  logic       any_bad;
  logic [2:0] nonred_cnt;
  logic [1:0] dir;
  logic       yel;

  assign lamp[0] = n_lights_i;
  assign lamp[1] = s_lights_i;
  assign lamp[2] = e_lights_i;
  assign lamp[3] = w_lights_i;

  // Classify the sample: bad encoding beats conflict beats dark; one non-red lamp gives the phase
  always_comb begin
    any_bad       = 1'b0;
    nonred_cnt    = 3'd0;
    dir           = 2'd0;
    yel           = 1'b0;
    phase_o       = PH_N;
    phase_valid_o = 1'b0;
    err_o         = DEC_OK;
    for (int i = 0; i < 4; i++) begin
      if (!(lamp[i] == RED || lamp[i] == YELLOW || lamp[i] == GREEN)) begin
        any_bad = 1'b1;
      end
      if (lamp[i] != RED) begin
        nonred_cnt = nonred_cnt + 3'd1;
        dir        = i[1:0];
        yel        = (lamp[i] == YELLOW);
      end
    end
    if (any_bad) begin
      err_o = DEC_ENC;
    end else if (nonred_cnt > 3'd1) begin
      err_o = DEC_CONFLICT;
    end else if (nonred_cnt == 3'd0) begin
      err_o = DEC_DARK;
    end else begin
      phase_o       = {dir, yel};
      phase_valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive lamp-bus checker; define TRAFFIC_MON_DURATION_EN to enable run-length (EARLY/LATE) checks
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 4,
  parameter int FCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic [2:0]        n_lights,
  input  logic [2:0]        s_lights,
  input  logic [2:0]        e_lights,
  input  logic [2:0]        w_lights,
  input  logic              clr_fault,
  output logic [2:0]        phase,
  output logic              phase_valid,
  output logic              locked,
  output logic              fault,
  output logic [2:0]        fault_code,
  output logic              fault_pulse,
  output logic [FCNT_W-1:0] fault_count
);

  logic [2:0]        dec_phase;
  logic              dec_valid;
  dec_err_e          dec_err;

  logic [2:0]        phase_q;
  logic              phase_valid_q;
  lock_state_e       lock_q, lock_d;
  logic              fault_q;
  logic [2:0]        fault_code_q;
  logic              fault_pulse_q;
  logic [FCNT_W-1:0] fault_count_q;

  logic              phase_change;
  logic              change_legal;
  logic [2:0]        new_code;
  logic              fault_hit;

  traffic_lamp_decode u_decode (
    .n_lights_i    (n_lights),
    .s_lights_i    (s_lights),
    .e_lights_i    (e_lights),
    .w_lights_i    (w_lights),
    .phase_o       (dec_phase),
    .phase_valid_o (dec_valid),
    .err_o         (dec_err)
  );

  // A change only counts between two valid samples; invalid samples leave no phase history
  assign phase_change = dec_valid && phase_valid_q && (dec_phase != phase_q);
  assign change_legal = (dec_phase == next_phase(phase_q));

`ifdef TRAFFIC_MON_DURATION_EN
  localparam int              RUN_W   = $clog2(GREEN_CYCLES + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(GREEN_CYCLES + 1);
  localparam logic [RUN_W-1:0] REQ_G   = RUN_W'(GREEN_CYCLES);
  localparam logic [RUN_W-1:0] REQ_Y   = RUN_W'(YELLOW_CYCLES);

  logic [RUN_W-1:0] run_q, run_d, run_req;

  // Run length of the current valid phase, restarting at 1 on change and saturating past the green limit
  always_comb begin
    run_req = phase_q[0] ? REQ_Y : REQ_G;
    run_d   = '0;
    if (dec_valid) begin
      if (phase_valid_q && (dec_phase == phase_q)) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
    end
  end

  // Run counter register
  always_ff @(posedge clk) begin
    if (rst_a) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  // Durations are not checked in this build; still reject meaningless settings at elaboration
  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_durations
    $error("traffic_light_monitor: phase durations must be at least 1");
  end
`endif

  // Pick the single highest-priority fault for this sample
  always_comb begin
    new_code = FC_NONE;
    case (dec_err)
      DEC_ENC:      new_code = FC_ENC;
      DEC_CONFLICT: new_code = FC_CONFLICT;
      DEC_DARK:     new_code = FC_DARK;
      default: begin
        if (lock_q == LK_LOCKED) begin
          if (phase_change && !change_legal) begin
            new_code = FC_SEQ;
`ifdef TRAFFIC_MON_DURATION_EN
          end else if (phase_change && (run_q < run_req)) begin
            new_code = FC_EARLY;
          end else if (!phase_change && (run_d == run_req + RUN_W'(1))) begin
            new_code = FC_LATE;
`endif
          end
        end
      end
    endcase
  end

  assign fault_hit = (new_code != FC_NONE);

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst_a) begin
      lock_q <= LK_UNLOCKED;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Lock FSM next state: sync on the first legal change, drop on any fault
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      LK_UNLOCKED: if (phase_change && change_legal && !fault_hit) lock_d = LK_LOCKED;
      LK_LOCKED:   if (fault_hit) lock_d = LK_UNLOCKED;
    endcase
  end

  // Lock FSM output
  always_comb begin
    locked = (lock_q == LK_LOCKED);
  end

  // Phase tracking: phase holds its last valid value across invalid samples
  always_ff @(posedge clk) begin
    if (rst_a) begin
      phase_q       <= PH_N;
      phase_valid_q <= 1'b0;
    end else begin
      phase_valid_q <= dec_valid;
      if (dec_valid) begin
        phase_q <= dec_phase;
      end
    end
  end

  // Fault reporting: a new fault beats a simultaneous clear and re-captures the code
  always_ff @(posedge clk) begin
    if (rst_a) begin
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      fault_pulse_q <= 1'b0;
      fault_count_q <= '0;
    end else begin
      fault_pulse_q <= fault_hit;
      if (fault_hit) begin
        fault_q <= 1'b1;
        if (!fault_q || clr_fault) begin
          fault_code_q <= new_code;
        end
        if (fault_count_q != {FCNT_W{1'b1}}) begin
          fault_count_q <= fault_count_q + FCNT_W'(1);
        end
      end else if (clr_fault) begin
        fault_q      <= 1'b0;
        fault_code_q <= FC_NONE;
      end
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_pulse = fault_pulse_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized self-checking bench with a behavioural model of the lamp monitor
module tb_traffic_light_monitor;

  localparam int G    = 8;
  localparam int Y    = 4;
  localparam int FW   = 8;
  localparam int CMAX = (1 << FW) - 1;
`ifdef TRAFFIC_MON_DURATION_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  logic          clk;
  logic          rst_a;
  logic [2:0]    n_lights, s_lights, e_lights, w_lights;
  logic          clr_fault;
  logic [2:0]    phase;
  logic          phase_valid;
  logic          locked;
  logic          fault;
  logic [2:0]    fault_code;
  logic          fault_pulse;
  logic [FW-1:0] fault_count;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int m_phase;
  bit m_pvalid;
  bit m_locked;
  int m_run;
  bit m_fault;
  int m_code;
  bit m_pulse;
  int m_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .FCNT_W        (FW)
  ) dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .n_lights    (n_lights),
    .s_lights    (s_lights),
    .e_lights    (e_lights),
    .w_lights    (w_lights),
    .clr_fault   (clr_fault),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_pulse (fault_pulse),
    .fault_count (fault_count)
  );

  function automatic logic [17:0] dut_vec();
    return {phase, phase_valid, locked, fault, fault_code, fault_pulse, fault_count};
  endfunction

  function automatic logic [17:0] mdl_vec();
    return {3'(m_phase), m_pvalid, m_locked, m_fault, 3'(m_code), m_pulse, 8'(m_count)};
  endfunction

  function automatic int req_len(input int p);
    return (p % 2 == 1) ? Y : G;
  endfunction

  // Drive one direction at the colour of phase p, all others red
  task automatic set_phase(input int p);
    logic [2:0] c;
    c = (p % 2 == 1) ? 3'b010 : 3'b001;
    n_lights = 3'b100;
    s_lights = 3'b100;
    e_lights = 3'b100;
    w_lights = 3'b100;
    case (p / 2)
      0: n_lights = c;
      1: s_lights = c;
      2: e_lights = c;
      default: w_lights = c;
    endcase
  endtask

  // Reference model: evaluate the rules on the sample just clocked in
  task automatic model_update();
    logic [2:0] l [4];
    int  nonred;
    int  dir;
    bit  yel;
    bit  bad;
    bit  valid;
    int  ph;
    int  code;
    bit  changed;
    bit  legal;
    int  newrun;
    int  req;
    l[0] = n_lights; l[1] = s_lights; l[2] = e_lights; l[3] = w_lights;
    if (rst_a) begin
      m_phase = 0; m_pvalid = 0; m_locked = 0; m_run = 0;
      m_fault = 0; m_code = 0; m_pulse = 0; m_count = 0;
      return;
    end
    nonred = 0; dir = 0; yel = 0; bad = 0; valid = 0; ph = 0; code = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(l[i] == 3'b100 || l[i] == 3'b010 || l[i] == 3'b001)) bad = 1;
      if (l[i] != 3'b100) begin
        nonred++;
        dir = i;
        yel = (l[i] == 3'b010);
      end
    end
    if (bad) code = 1;
    else if (nonred > 1) code = 2;
    else if (nonred == 0) code = 3;
    else begin
      valid = 1;
      ph = dir * 2 + (yel ? 1 : 0);
    end
    changed = valid && m_pvalid && (ph != m_phase);
    legal   = (ph == (m_phase + 1) % 8);
    if (!valid) newrun = 0;
    else if (m_pvalid && ph == m_phase) newrun = (m_run + 1 > G + 1) ? G + 1 : m_run + 1;
    else newrun = 1;
    req = req_len(m_phase);
    if (code == 0 && m_locked) begin
      if (changed && !legal) code = 4;
      else if (DUR && changed && m_run < req) code = 5;
      else if (DUR && !changed && newrun == req + 1) code = 6;
    end
    if (code != 0) m_locked = 0;
    else if (!m_locked && changed && legal) m_locked = 1;
    m_pulse = (code != 0);
    if (m_pulse) begin
      if (m_count < CMAX) m_count++;
      if (!m_fault || clr_fault) m_code = code;
      m_fault = 1;
    end else if (clr_fault) begin
      m_fault = 0;
      m_code = 0;
    end
    if (valid) m_phase = ph;
    m_pvalid = valid;
    m_run = newrun;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    clr_fault = 1'b0;
    step();
    rst_a = 1'b0;
  endtask

  // Reset, then W green and W yellow so the monitor is locked entering N green
  task automatic lock_at_w();
    do_reset();
    for (int k = 0; k < G; k++) begin set_phase(6); step(); end
    for (int k = 0; k < Y; k++) begin set_phase(7); step(); end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    clr_fault = 1'(($urandom_range(0, 1)));
    {n_lights, s_lights, e_lights, w_lights} = 12'($urandom);
    step();
    {n_lights, s_lights, e_lights, w_lights} = 12'($urandom);
    step();
    checks++;
    if (dut_vec() !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 18'h0);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dut_vec(), mdl_vec());
    end
    rst_a = 1'b0;
    clr_fault = 1'b0;
  endtask

  task automatic test_legal_cycle();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < 8; p++) begin
        for (int k = 0; k < req_len(p); k++) begin
          set_phase(p);
          step();
          checks++;
          if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL legal_model p=%0d k=%0d: got %h expected %h", p, k, dut_vec(), mdl_vec());
          end
          checks++;
          if (phase !== 3'(p) || fault !== 1'b0) begin
            errors++;
            $display("FAIL legal_track p=%0d: got phase=%0d fault=%0b expected phase=%0d fault=0", p, phase, fault, p);
          end
          if (rep == 0 && p == 1 && k == 0) begin
            checks++;
            if (locked !== 1'b1) begin
              errors++;
              $display("FAIL legal_lock_first_change: got %0b expected 1", locked);
            end
          end
        end
      end
    end
  endtask

  task automatic test_conflict();
    n_lights = 3'b001; s_lights = 3'b100; e_lights = 3'b001; w_lights = 3'b100;
    step();
    checks++;
    if ({fault_pulse, fault, fault_code, fault_count, locked} !== {1'b1, 1'b1, 3'd2, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL conflict: got pulse=%0b fault=%0b code=%0d count=%0d locked=%0b expected 1 1 2 1 0",
               fault_pulse, fault, fault_code, fault_count, locked);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL conflict_model: got %h expected %h", dut_vec(), mdl_vec());
    end
    set_phase(0);
    step();
    checks++;
    if (fault_pulse !== 1'b0 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL conflict_after: got pulse=%0b code=%0d expected 0 2", fault_pulse, fault_code);
    end
  endtask

  task automatic test_duration_late();
    int pulses;
    lock_at_w();
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      set_phase(0);
      step();
      if (fault_pulse) pulses++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL late_model k=%0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
      if (k == 8) begin
        checks++;
        if (fault_code !== (DUR ? 3'd6 : 3'd0) || fault_pulse !== DUR) begin
          errors++;
          $display("FAIL late_code: got code=%0d pulse=%0b expected code=%0d pulse=%0b",
                   fault_code, fault_pulse, DUR ? 6 : 0, DUR);
        end
      end
    end
    checks++;
    if (pulses !== (DUR ? 1 : 0)) begin
      errors++;
      $display("FAIL late_once: got %0d pulses expected %0d", pulses, DUR ? 1 : 0);
    end
  endtask

  task automatic test_duration_early();
    lock_at_w();
    for (int k = 0; k < 6; k++) begin set_phase(0); step(); end
    set_phase(1);
    step();
    checks++;
    if (fault_code !== (DUR ? 3'd5 : 3'd0) || fault !== DUR) begin
      errors++;
      $display("FAIL early_code: got code=%0d fault=%0b expected code=%0d fault=%0b",
               fault_code, fault, DUR ? 5 : 0, DUR);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL early_model: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_seq_clear();
    lock_at_w();
    for (int k = 0; k < G; k++) begin set_phase(0); step(); end
    for (int k = 0; k < Y; k++) begin set_phase(1); step(); end
    set_phase(4);
    step();
    checks++;
    if ({fault, fault_code, fault_pulse, fault_count, locked} !== {1'b1, 3'd4, 1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL seq: got fault=%0b code=%0d pulse=%0b count=%0d locked=%0b expected 1 4 1 1 0",
               fault, fault_code, fault_pulse, fault_count, locked);
    end
    n_lights = 3'b011; s_lights = 3'b100; e_lights = 3'b100; w_lights = 3'b100;
    clr_fault = 1'b1;
    step();
    checks++;
    if ({fault, fault_code, fault_count} !== {1'b1, 3'd1, 8'd2}) begin
      errors++;
      $display("FAIL clr_with_fault: got fault=%0b code=%0d count=%0d expected 1 1 2", fault, fault_code, fault_count);
    end
    set_phase(4);
    step();
    checks++;
    if ({fault, fault_code, fault_count, fault_pulse} !== {1'b0, 3'd0, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL clr_alone: got fault=%0b code=%0d count=%0d pulse=%0b expected 0 0 2 0",
               fault, fault_code, fault_count, fault_pulse);
    end
    clr_fault = 1'b0;
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL seq_model: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_saturation_reset();
    logic [2:0] bad_codes [5];
    bad_codes[0] = 3'b000; bad_codes[1] = 3'b011; bad_codes[2] = 3'b101;
    bad_codes[3] = 3'b110; bad_codes[4] = 3'b111;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      set_phase(int'($urandom_range(0, 7)));
      n_lights = bad_codes[$urandom_range(0, 4)];
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL sat_model k=%0d: got %h expected %h", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (fault_count !== 8'(CMAX) || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL sat_count: got count=%0d code=%0d expected %0d 1", fault_count, fault_code, CMAX);
    end
    for (int k = 0; k < G; k++) begin set_phase(2); step(); end
    for (int k = 0; k < 2; k++) begin set_phase(3); step(); end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++;
    if (dut_vec() !== 18'h0) begin
      errors++;
      $display("FAIL midrun_reset: got %h expected %h", dut_vec(), 18'h0);
    end
    for (int k = 0; k < 3; k++) begin
      set_phase(3);
      step();
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL reset_unlocked k=%0d: got %0b expected 0", k, locked);
      end
    end
    set_phase(4);
    step();
    checks++;
    if (locked !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL relock: got locked=%0b fault=%0b expected 1 0", locked, fault);
    end
  endtask

  task automatic test_random();
    int cur;
    int len;
    int cyc;
    do_reset();
    cur = int'($urandom_range(0, 7));
    cyc = 0;
    while (cyc < 1500) begin
      if ($urandom_range(0, 7) == 0) len = int'($urandom_range(1, 12));
      else len = req_len(cur) + int'($urandom_range(0, 2)) - 1;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 63) == 0) {n_lights, s_lights, e_lights, w_lights} = 12'($urandom);
        else set_phase(cur);
        clr_fault = ($urandom_range(0, 15) == 0);
        rst_a = ($urandom_range(0, 299) == 0);
        step();
        cyc++;
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++;
          $display("FAIL random_model cyc=%0d: got %h expected %h", cyc, dut_vec(), mdl_vec());
        end
      end
      if ($urandom_range(0, 9) == 0) cur = int'($urandom_range(0, 7));
      else cur = (cur + 1) % 8;
    end
    rst_a = 1'b0;
    clr_fault = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1;
    clr_fault = 1'b0;
    n_lights = 3'b100; s_lights = 3'b100; e_lights = 3'b100; w_lights = 3'b100;
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_duration_late();
    test_duration_early();
    test_seq_clear();
    test_saturation_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the four lamp buses driven by the intersection controller; it never drives them.
- Decodes the lamp buses into a phase code and checks encoding, mutual exclusion, phase order (N→S→E→W) and phase durations.
- Reports a sticky fault, the first fault code, a per-fault pulse and a saturating fault count for the status/debug block.

Parameters:
- GREEN_CYCLES, 8: required green run length, in clk cycles.
- YELLOW_CYCLES, 4: required yellow run length, in clk cycles.
- FCNT_W, 8: width of fault_count.

Ports:
- clk  in  1: single clock; all logic on posedge.
- rst_a  in  1: reset, synchronous, active-high.
- n_lights  in  3: north lamp; 100 red, 010 yellow, 001 green.
- s_lights  in  3: south lamp, same encoding.
- e_lights  in  3: east lamp, same encoding.
- w_lights  in  3: west lamp, same encoding.
- clr_fault  in  1: clears fault and fault_code.
- phase  out  3: decoded phase: 000 N, 001 N_Y, 010 S, 011 S_Y, 100 E, 101 E_Y, 110 W, 111 W_Y.
- phase_valid  out  1: current sample decoded to a legal single-direction phase.
- locked  out  1: monitor synchronised to the controller's sequence.
- fault  out  1: sticky fault flag.
- fault_code  out  3: code of the first fault since the last clear.
- fault_pulse  out  1: one-cycle strobe per detected fault.
- fault_count  out  FCNT_W: saturating count of faults.

Behaviour:
- All outputs are registered. A sample taken at edge k is reflected in the outputs after edge k, giving 1-cycle latency.
- Reset (synchronous rst_a high) sets: phase=000, phase_valid=0, locked=0, fault=0, fault_code=000, fault_pulse=0, fault_count=0, run counter=0.
- Reset mid-run discards all history.
- Decode of each sample:
  - Encoding check: each lamp must be exactly one of 100/010/001.
  - Legal sample: exactly one direction non-red. Its colour selects the phase.
- Fault codes, highest priority first; only one code is reported per cycle:
  - 1 ENC: any lamp not one-hot.
  - 2 CONFLICT: two or more directions non-red.
  - 3 DARK: all four directions red.
  - 4 SEQ: illegal phase change while locked. Legal changes are X green→X yellow and X yellow→next direction green, with W_Y→N wrapping.
  - 5 EARLY: phase changes while locked and run length L < required.
  - 6 LATE: run length reaches required+1 while locked. Reported once per run.
- Codes 1–3 are checked on every sample regardless of locked. While phase_valid=0, phase holds its last valid value.
- Run counter L counts consecutive samples of the same valid phase. It restarts at 1 on a phase change and saturates at GREEN_CYCLES+1.
- Required L: GREEN_CYCLES for green phases, YELLOW_CYCLES for yellow phases.
- Lock FSM:
  - UNLOCKED→LOCKED on the first legal phase change between two valid samples. The duration of the first, partial run is not checked.
  - LOCKED→UNLOCKED on any fault.
  - SEQ and duration checks are active only in LOCKED.
- On a fault:
  - fault_pulse=1 for one cycle.
  - fault_count increments, saturating at all-ones.
  - fault goes to 1.
  - fault_code is loaded only if fault was 0 (first fault is retained).
- Simultaneous clr_fault and new fault: the new fault wins. fault stays 1 and fault_code is set to the new code.
- clr_fault alone: fault=0 and fault_code=000. fault_count is unaffected and is cleared only by reset.

Optional Feature:
- Macro: TRAFFIC_MON_DURATION_EN.
- Defined: codes 5/6 are checked and the run counter is present.
- Undefined: run counter removed, codes 5/6 never produced. ENC/CONFLICT/DARK/SEQ and lock behaviour are unchanged.

Decomposition:
- Package traffic_pkg holds:
  - Lamp encoding constants: RED, YELLOW, GREEN.
  - The 3-bit phase codes.
  - The fault code constants.
- One sub-module, traffic_lamp_decode: combinational decode of the four lamp buses to phase, phase_valid and an error class (none/ENC/CONFLICT/DARK).

Test Plan:
- Legal cycle: drive 8 N, 4 N_Y, 8 S, 4 S_Y, 8 E, 4 E_Y, 8 W, 4 W_Y, repeated twice → locked=1 after the first change; fault=0; phase tracks with 1-cycle lag.
- Conflict: while locked, drive n=001 and e=001 for 1 cycle → fault_pulse=1, fault_code=2, fault_count=1, locked=0.
- Duration:
  - N green held for 9 cycles → code 6 at the 9th sample, only once.
  - Separately, N green held for 6 cycles then N_Y → code 5.
- Sequence and clear: N_Y→E → code 4. Then assert clr_fault with n=011 in the same cycle → fault=1, fault_code=1, fault_count incremented.
- Saturation and reset: inject 300 ENC faults → fault_count=255. Then assert rst_a for 1 cycle mid-run → all outputs 0, locked=0 until the next legal change.
- Macro undefined: repeat the duration scenario → no fault; the conflict scenario is unchanged.
